// File: rtl/cmem_arbiter_pkg.sv
// Shared constants for the layer-memory arbiter: requester indices, csel codes, FSM states.
package cmem_arbiter_pkg;

  localparam logic REQ_ENGINE = 1'b0;
  localparam logic REQ_HOST   = 1'b1;

  typedef enum logic [2:0] {
    CSEL_NONE = 3'd0,
    L0_K0     = 3'd1,
    L0_K1     = 3'd2,
    L1_K0     = 3'd3,
    L1_K1     = 3'd4,
    L2        = 3'd5
  } csel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  // Lock-owner state for a granted requester index.
  function automatic state_e own_state(input logic idx);
    return (idx == REQ_HOST) ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/cmem_rd_tag_pipe.sv
// Read-return tracker: RD_LAT-deep shift register of {valid, owner} following mem_rd.
module cmem_rd_tag_pipe #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_vld,
  input  logic in_own,
  output logic out_vld,
  output logic out_own
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] own_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q[0] <= in_vld;
      own_q[0] <= in_own;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[RD_LAT-1];
  assign out_own = own_q[RD_LAT-1];

endmodule

// File: rtl/cmem_arbiter.sv
// Two-requester (engine/host) arbiter for the layer memory with lock ownership,
// bounded hold time, registered memory strobes and tagged read return.
module cmem_arbiter
  import cmem_arbiter_pkg::*;
#(
  parameter int unsigned AW       = 12,
  parameter int unsigned DW       = 20,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           rq_req,
  input  logic [1:0]           rq_we,
  input  logic [1:0]           rq_lock,
  input  logic [1:0][2:0]      rq_sel,
  input  logic [1:0][AW-1:0]   rq_addr,
  input  logic [1:0][DW-1:0]   rq_wdata,
  output logic [1:0]           rq_gnt,
  output logic [1:0]           rq_rvalid,
  output logic [1:0][DW-1:0]   rq_rdata,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [2:0]           mem_sel,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int unsigned HW = $clog2(HOLD_MAX + 1);

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      gnt_raw;
  logic            forced;
  logic            gnt_any;
  logic            gnt_idx;
  logic            mem_own_q;
  logic            pipe_vld, pipe_own;
  logic [1:0][DW-1:0] rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= REQ_HOST;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // Grant selection; an owner past its hold budget yields one cycle to a waiting peer.
  always_comb begin
    gnt_raw = '0;
    forced  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (&rq_req) gnt_raw = ptr_q ? 2'b01 : 2'b10;
        else         gnt_raw = rq_req;
      end
      ST_OWN0: begin
        if (hold_q >= HW'(HOLD_MAX) && rq_req[1]) begin
          gnt_raw = 2'b10;
          forced  = 1'b1;
        end else begin
          gnt_raw = {1'b0, rq_req[0]};
        end
      end
      ST_OWN1: begin
        if (hold_q >= HW'(HOLD_MAX) && rq_req[0]) begin
          gnt_raw = 2'b01;
          forced  = 1'b1;
        end else begin
          gnt_raw = {rq_req[1], 1'b0};
        end
      end
      default: gnt_raw = '0;
    endcase
    rq_gnt = reset_n ? gnt_raw : 2'b00;
  end

  assign gnt_any = |rq_gnt;
  assign gnt_idx = rq_gnt[1];

  always_comb begin
    state_d = ST_IDLE;
    ptr_d   = ptr_q;
    hold_d  = '0;
    if (gnt_any) begin
      ptr_d = gnt_idx;
      if (rq_lock[gnt_idx]) state_d = own_state(gnt_idx);
      if (!forced && rq_req[!gnt_idx])
        hold_d = (gnt_idx == ptr_q) ? hold_q + HW'(1) : HW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_sel   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_own_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      mem_rd <= gnt_any & ~rq_we[gnt_idx];
      mem_wr <= gnt_any &  rq_we[gnt_idx];
      if (gnt_any) begin
        mem_sel   <= rq_sel[gnt_idx];
        mem_addr  <= rq_addr[gnt_idx];
        mem_wdata <= rq_wdata[gnt_idx];
        mem_own_q <= gnt_idx;
      end
      for (int i = 0; i < 2; i++)
        if (rq_rvalid[i]) rdata_q[i] <= mem_rdata;
    end
  end

  cmem_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .in_vld  (mem_rd),
    .in_own  (mem_own_q),
    .out_vld (pipe_vld),
    .out_own (pipe_own)
  );

  assign rq_rvalid[REQ_ENGINE] = pipe_vld & (pipe_own == REQ_ENGINE);
  assign rq_rvalid[REQ_HOST]   = pipe_vld & (pipe_own == REQ_HOST);

  // Returning data is passed straight through; non-owners keep their last word.
  always_comb begin
    for (int i = 0; i < 2; i++)
      rq_rdata[i] = rq_rvalid[i] ? mem_rdata : rdata_q[i];
  end

endmodule

// File: tb/tb_cmem_arbiter.sv
// Directed bench for cmem_arbiter: a vector table plus hand sequences for hold and reset.
module tb_cmem_arbiter;
  import cmem_arbiter_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 20;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [1:0]         req, we, lock;
  logic [1:0][2:0]    sel;
  logic [1:0][AW-1:0] addr;
  logic [1:0][DW-1:0] wdata;

  logic [1:0]         gnt1, rv1, gnt3, rv3;
  logic [1:0][DW-1:0] rdat1, rdat3;
  logic               m1_rd, m1_wr, m3_rd, m3_wr;
  logic [2:0]         m1_sel, m3_sel;
  logic [AW-1:0]      m1_addr, m3_addr;
  logic [DW-1:0]      m1_wdata, m3_wdata, m1_rdata, m3_rdata;

  cmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .HOLD_MAX(16)) dut (
    .clk(clk), .reset_n(reset_n), .rq_req(req), .rq_we(we), .rq_lock(lock),
    .rq_sel(sel), .rq_addr(addr), .rq_wdata(wdata), .rq_gnt(gnt1),
    .rq_rvalid(rv1), .rq_rdata(rdat1), .mem_rd(m1_rd), .mem_wr(m1_wr),
    .mem_sel(m1_sel), .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_rdata(m1_rdata));

  cmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .HOLD_MAX(16)) dut3 (
    .clk(clk), .reset_n(reset_n), .rq_req(req), .rq_we(we), .rq_lock(lock),
    .rq_sel(sel), .rq_addr(addr), .rq_wdata(wdata), .rq_gnt(gnt3),
    .rq_rvalid(rv3), .rq_rdata(rdat3), .mem_rd(m3_rd), .mem_wr(m3_wr),
    .mem_sel(m3_sel), .mem_addr(m3_addr), .mem_wdata(m3_wdata), .mem_rdata(m3_rdata));

  function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
    return DW'(20'hD0000) | DW'(a);
  endfunction

  // Memory models: data is a function of the address presented RD_LAT cycles earlier.
  logic [AW-1:0] ap1;
  logic [AW-1:0] ap3 [3];
  always @(posedge clk) begin
    ap1    <= m1_addr;
    ap3[0] <= m3_addr;
    ap3[1] <= ap3[0];
    ap3[2] <= ap3[1];
  end
  assign m1_rdata = fdat(ap1);
  assign m3_rdata = fdat(ap3[2]);

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          rst_before;
    logic [1:0]    req, we;
    logic [AW-1:0] a0, a1;
    logic [2:0]    sel1;
    logic [DW-1:0] wd1;
    logic [1:0]    gnt;
    logic          mrd, mwr;
    logic [2:0]    msel;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwd;
    logic [1:0]    rv, rv3;
    logic [DW-1:0] rd0, rd1;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rb, input logic [1:0] rq, input logic [1:0] w,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [2:0] s1, input logic [DW-1:0] wd1,
                     input logic [1:0] g, input logic mrd, input logic mwr,
                     input logic [2:0] ms, input logic [AW-1:0] ma, input logic [DW-1:0] mw,
                     input logic [1:0] rv, input logic [1:0] rvb,
                     input logic [DW-1:0] rd0, input logic [DW-1:0] rd1);
    vec_t v;
    v.rst_before = rb; v.req = rq; v.we = w; v.a0 = a0; v.a1 = a1; v.sel1 = s1;
    v.wd1 = wd1; v.gnt = g; v.mrd = mrd; v.mwr = mwr; v.msel = ms; v.maddr = ma;
    v.mwd = mw; v.rv = rv; v.rv3 = rvb; v.rd0 = rd0; v.rd1 = rd1;
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    req = '0; we = '0; lock = '0; sel = '0; addr = '0; wdata = '0;
  endtask

  // Leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic run_row(input vec_t v);
    if (v.rst_before) do_reset();
    req = v.req; we = v.we; lock = '0;
    sel[0] = 3'(L0_K0); sel[1] = v.sel1;
    addr[0] = v.a0; addr[1] = v.a1;
    wdata[0] = '0;  wdata[1] = v.wd1;
    @(negedge clk);
    chk("gnt",      32'(gnt1),  32'(v.gnt));
    chk("gnt_lat3", 32'(gnt3),  32'(v.gnt));
    chk("mem_rd",   32'(m1_rd), 32'(v.mrd));
    chk("mem_wr",   32'(m1_wr), 32'(v.mwr));
    if (v.mrd || v.mwr) begin
      chk("mem_sel",  32'(m1_sel),  32'(v.msel));
      chk("mem_addr", 32'(m1_addr), 32'(v.maddr));
    end
    if (v.mwr) chk("mem_wdata", 32'(m1_wdata), 32'(v.mwd));
    chk("rvalid",      32'(rv1),      32'(v.rv));
    chk("rvalid_lat3", 32'(rv3),      32'(v.rv3));
    chk("rdata0",      32'(rdat1[0]), 32'(v.rd0));
    chk("rdata1",      32'(rdat1[1]), 32'(v.rd1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    req = 2'b11;
    #12;
    chk("rst_gnt",    32'(gnt1),     32'd0);
    chk("rst_mem_rd", 32'(m1_rd),    32'd0);
    chk("rst_mem_wr", 32'(m1_wr),    32'd0);
    chk("rst_sel",    32'(m1_sel),   32'd0);
    chk("rst_addr",   32'(m1_addr),  32'd0);
    chk("rst_wdata",  32'(m1_wdata), 32'd0);
    chk("rst_rvalid", 32'(rv1),      32'd0);
    chk("rst_rdata",  32'(rdat1),    32'd0);

    // Engine-only back-to-back reads 0..3.
    add(1, 2'b01, 2'b00, 12'h000, 12'h000, 3'd0, 20'h0, 2'b01, 0, 0, 3'd0, 12'h000, 20'h0, 2'b00, 2'b00, 20'h0,      20'h0);
    add(0, 2'b01, 2'b00, 12'h001, 12'h000, 3'd0, 20'h0, 2'b01, 1, 0, 3'd1, 12'h000, 20'h0, 2'b00, 2'b00, 20'h0,      20'h0);
    add(0, 2'b01, 2'b00, 12'h002, 12'h000, 3'd0, 20'h0, 2'b01, 1, 0, 3'd1, 12'h001, 20'h0, 2'b01, 2'b00, fdat(12'h0), 20'h0);
    add(0, 2'b01, 2'b00, 12'h003, 12'h000, 3'd0, 20'h0, 2'b01, 1, 0, 3'd1, 12'h002, 20'h0, 2'b01, 2'b00, fdat(12'h1), 20'h0);
    add(0, 2'b00, 2'b00, 12'h000, 12'h000, 3'd0, 20'h0, 2'b00, 1, 0, 3'd1, 12'h003, 20'h0, 2'b01, 2'b01, fdat(12'h2), 20'h0);
    add(0, 2'b00, 2'b00, 12'h000, 12'h000, 3'd0, 20'h0, 2'b00, 0, 0, 3'd0, 12'h000, 20'h0, 2'b01, 2'b01, fdat(12'h3), 20'h0);
    add(0, 2'b00, 2'b00, 12'h000, 12'h000, 3'd0, 20'h0, 2'b00, 0, 0, 3'd0, 12'h000, 20'h0, 2'b00, 2'b01, fdat(12'h3), 20'h0);
    add(0, 2'b00, 2'b00, 12'h000, 12'h000, 3'd0, 20'h0, 2'b00, 0, 0, 3'd0, 12'h000, 20'h0, 2'b00, 2'b01, fdat(12'h3), 20'h0);
    // Both requesting unlocked from reset: grants alternate, returns routed per requester.
    add(1, 2'b11, 2'b00, 12'h010, 12'h020, 3'(L0_K1), 20'h0, 2'b01, 0, 0, 3'd0, 12'h000, 20'h0, 2'b00, 2'b00, 20'h0, 20'h0);
    add(0, 2'b11, 2'b00, 12'h011, 12'h021, 3'(L0_K1), 20'h0, 2'b10, 1, 0, 3'd1, 12'h010, 20'h0, 2'b00, 2'b00, 20'h0, 20'h0);
    add(0, 2'b11, 2'b00, 12'h012, 12'h022, 3'(L0_K1), 20'h0, 2'b01, 1, 0, 3'd2, 12'h021, 20'h0, 2'b01, 2'b00, fdat(12'h010), 20'h0);
    add(0, 2'b11, 2'b00, 12'h013, 12'h023, 3'(L0_K1), 20'h0, 2'b10, 1, 0, 3'd1, 12'h012, 20'h0, 2'b10, 2'b00, fdat(12'h010), fdat(12'h021));
    add(0, 2'b00, 2'b00, 12'h000, 12'h000, 3'(L0_K1), 20'h0, 2'b00, 1, 0, 3'd2, 12'h023, 20'h0, 2'b01, 2'b01, fdat(12'h012), fdat(12'h021));
    add(0, 2'b00, 2'b00, 12'h000, 12'h000, 3'(L0_K1), 20'h0, 2'b00, 0, 0, 3'd0, 12'h000, 20'h0, 2'b10, 2'b10, fdat(12'h012), fdat(12'h023));
    add(0, 2'b00, 2'b00, 12'h000, 12'h000, 3'(L0_K1), 20'h0, 2'b00, 0, 0, 3'd0, 12'h000, 20'h0, 2'b00, 2'b01, fdat(12'h012), fdat(12'h023));
    add(0, 2'b00, 2'b00, 12'h000, 12'h000, 3'(L0_K1), 20'h0, 2'b00, 0, 0, 3'd0, 12'h000, 20'h0, 2'b00, 2'b10, fdat(12'h012), fdat(12'h023));
    // Host write, sel L2: strobes one cycle after grant, no read return.
    add(0, 2'b10, 2'b10, 12'h000, 12'h0A5, 3'(L2), 20'h12345, 2'b10, 0, 0, 3'd0, 12'h000, 20'h0,     2'b00, 2'b00, fdat(12'h012), fdat(12'h023));
    add(0, 2'b00, 2'b00, 12'h000, 12'h000, 3'(L2), 20'h0,     2'b00, 0, 1, 3'd5, 12'h0A5, 20'h12345, 2'b00, 2'b00, fdat(12'h012), fdat(12'h023));
    add(0, 2'b00, 2'b00, 12'h000, 12'h000, 3'(L2), 20'h0,     2'b00, 0, 0, 3'd0, 12'h000, 20'h0,     2'b00, 2'b00, fdat(12'h012), fdat(12'h023));
    add(0, 2'b00, 2'b00, 12'h000, 12'h000, 3'(L2), 20'h0,     2'b00, 0, 0, 3'd0, 12'h000, 20'h0,     2'b00, 2'b00, fdat(12'h012), fdat(12'h023));

    foreach (tbl[i]) run_row(tbl[i]);

    // Engine locked with host waiting: 16 engine grants, one host grant, engine resumes.
    do_reset();
    req = 2'b11; lock = 2'b01;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("hold_gnt[%0d]", c), 32'(gnt1), (c == 16) ? 32'd2 : 32'd1);
      @(posedge clk);
      #1;
    end

    // Reset with two reads in flight on the RD_LAT=3 instance.
    do_reset();
    req = 2'b01; addr[0] = 12'h030;
    @(posedge clk); #1;
    addr[0] = 12'h031;
    @(negedge clk);
    chk("lat3_rd_issue", 32'(m3_rd), 32'd1);
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    chk("lat3_rd_second", 32'(m3_rd),   32'd1);
    chk("lat3_addr",      32'(m3_addr), 32'h031);
    @(posedge clk); #1;
    req = 2'b01;
    reset_n = 1'b0;
    #2;
    chk("mid_rst_gnt",    32'(gnt3),     32'd0);
    chk("mid_rst_mem_rd", 32'(m3_rd),    32'd0);
    chk("mid_rst_mem_wr", 32'(m3_wr),    32'd0);
    chk("mid_rst_sel",    32'(m3_sel),   32'd0);
    chk("mid_rst_addr",   32'(m3_addr),  32'd0);
    chk("mid_rst_wdata",  32'(m3_wdata), 32'd0);
    chk("mid_rst_rvalid", 32'(rv3),      32'd0);
    chk("mid_rst_rdata",  32'(rdat3),    32'd0);
    req = 2'b00;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_rvalid[%0d]", c), 32'(rv3), 32'd0);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cmem_arbiter.md
CMEM_ARBITER -- requirements
Module: cmem_arbiter

Interface
REQ-001 Parameter AW, default 12, layer-memory address width.
REQ-002 Parameter DW, default 20, layer-memory data width.
REQ-003 Parameter RD_LAT, default 1, cycles from mem_rd high to mem_rdata valid; legal range 1..4.
REQ-004 Parameter HOLD_MAX, default 16, maximum consecutive locked grants to one requester while the other waits.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 rq_req[i], i=0 engine, i=1 host  input  1 each  access request.
REQ-008 rq_we[i]  input  1 each  1=write, 0=read.
REQ-009 rq_lock[i]  input  1 each  request to keep ownership on the next cycle.
REQ-010 rq_sel[i]  input  3 each  layer-memory select (csel encoding).
REQ-011 rq_addr[i] / rq_wdata[i]  input  AW / DW each  address / write data.
REQ-012 rq_gnt[i]  output  1 each  combinational; access accepted this cycle.
REQ-013 rq_rvalid[i] / rq_rdata[i]  output  1 / DW each  returned read data.
REQ-014 mem_rd, mem_wr  output  1  registered strobes to layer memory.
REQ-015 mem_sel / mem_addr / mem_wdata  output  3 / AW / DW  registered.
REQ-016 mem_rdata  input  DW  memory read data.

Function
REQ-017 At most one rq_gnt high per cycle; rq_gnt[i] high only if rq_req[i] high.
REQ-018 FSM states: IDLE, OWN0, OWN1; OWNi = requester i holds a lock.
REQ-019 IDLE: single requester granted; both requesting -> requester not granted last (round-robin pointer, reset value 1, so engine wins first tie).
REQ-020 Granted with rq_lock[i]=1 -> next state OWNi; otherwise IDLE.
REQ-021 OWNi: rq_req[i]=1 -> i granted regardless of other; rq_req[i]=0 or rq_lock[i]=0 on a grant -> IDLE after that cycle.
REQ-022 OWNi: hold counter counts consecutive grants while other requester waits; at HOLD_MAX, next cycle forced to the other requester (state OWNj if its lock high, else IDLE), counter cleared.
REQ-023 Hold counter cleared whenever other requester is not requesting or ownership changes.
REQ-024 Accepted access appears on mem_* exactly 1 cycle after rq_gnt; mem_rd/mem_wr low in cycles with no grant; mem_wr=rq_we, mem_rd=!rq_we.
REQ-025 Read return: rq_rvalid[i] high and rq_rdata[i]=mem_rdata exactly RD_LAT cycles after mem_rd; owner tag tracked in RD_LAT-deep shift register; back-to-back reads from alternating requesters return in order, no bubbles.
REQ-026 rq_rdata[j] for non-owner j holds last value; rq_rvalid low.
REQ-027 Writes produce no rq_rvalid.
REQ-028 Round-robin pointer updated on every grant to granted index.

Reset
REQ-029 reset_n low: state IDLE, pointer 1, hold counter 0, tag pipeline empty, mem_rd=mem_wr=0, mem_sel=0, mem_addr=0, mem_wdata=0, rq_rvalid=0, rq_rdata=0; rq_gnt low.
REQ-030 Reset mid-access: in-flight reads discarded; no rq_rvalid after release until a new read is granted.

Structure
REQ-031 Shared package holds requester index constants (REQ_ENGINE=0, REQ_HOST=1), csel encodings (L0_K0=1, L0_K1=2, L1_K0=3, L1_K1=4, L2=5), and FSM state encoding.
REQ-032 One sub-module, cmem_rd_tag_pipe: RD_LAT-deep valid/owner shift register.

Verification
REQ-033 Engine only, reads addr 0x000..0x003 back to back, RD_LAT=1 -> mem_rd high 4 cycles starting 1 after first gnt, rq_rvalid[0] for 4 cycles starting 2 after, data in order.
REQ-034 Both request unlocked every cycle from reset -> grants alternate 0,1,0,1; rq_rvalid routed per requester.
REQ-035 Engine locked continuously, host requesting, HOLD_MAX=16 -> 16 engine grants, 1 host grant, then engine resumes.
REQ-036 Host write sel=5 addr 0x0A5 data 0x12345 -> mem_wr=1, mem_sel=5, mem_addr=0x0A5, mem_wdata=0x12345 one cycle later; no rq_rvalid.
REQ-037 reset_n asserted with RD_LAT=3 and 2 reads in flight -> all outputs at reset values, no rq_rvalid after release.
